// File: rtl/full_handshake_tx_if.sv
`timescale 1ns/1ps
// Bundle of local-client and cross-domain signals around the four-phase TX block.
// Latency: none, wires only.
// Backpressure: the client must gate req_i on idle_o; the RX side answers req_o with ack_i.
interface full_handshake_tx_if #(
    parameter int DW = 32
);
    logic          ack_i;
    logic          req_i;
    logic [DW-1:0] req_data_i;
    logic          idle_o;
    logic          req_o;
    logic [DW-1:0] req_data_o;
    logic          done_o;

    // TX block view
    modport master (
        input  ack_i,
        input  req_i,
        input  req_data_i,
        output idle_o,
        output req_o,
        output req_data_o,
        output done_o
    );

    // Client / RX-peer view
    modport slave (
        output ack_i,
        output req_i,
        output req_data_i,
        input  idle_o,
        input  req_o,
        input  req_data_o,
        input  done_o
    );
endinterface

// File: rtl/full_handshake_tx.sv
`timescale 1ns/1ps
// Transmit side of a four-phase req/ack clock-domain crossing for one DW-bit word.
// Latency: req_o one cycle after accept; req_o drops 3 edges after ack_i rises; done_o 3 edges after ack_i falls.
// Backpressure: idle_o low while a handshake is in flight or a stale ack is seen; requests then are dropped.
module full_handshake_tx #(
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    full_handshake_tx_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'b001,
        ASSERT   = 3'b010,
        DEASSERT = 3'b100
    } state_t;

    state_t        state;
    state_t        state_nxt;

    logic          ack_d;
    logic          ack_s;

    logic          req_q;
    logic          req_nxt;
    logic          done_q;
    logic          done_nxt;
    logic          load;
    logic [DW-1:0] data_q;

    logic          idle;
    logic          accept;

    // Two-flop synchronizer for the asynchronous ack; only ack_s is used below.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ack_d <= 1'b0;
            ack_s <= 1'b0;
        end else begin
            ack_d <= bus.ack_i;
            ack_s <= ack_d;
        end
    end

    // A lingering ack from the peer (e.g. across our reset) blocks new requests
    // so a fresh req cannot be mistaken as already acknowledged.
    assign idle   = (state == IDLE) && !ack_s;
    assign accept = idle && bus.req_i;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; any illegal one-hot pattern recovers to IDLE.
    always_comb begin
        state_nxt = IDLE;
        case (state)
            IDLE:     state_nxt = accept ? ASSERT : IDLE;
            ASSERT:   state_nxt = ack_s ? DEASSERT : ASSERT;
            DEASSERT: state_nxt = ack_s ? DEASSERT : IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // Next values for the registered outputs, decoded from the current state.
    always_comb begin
        req_nxt  = 1'b0;
        done_nxt = 1'b0;
        load     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    req_nxt = 1'b1;
                    load    = 1'b1;
                end
            end
            ASSERT: begin
                req_nxt = !ack_s;
            end
            DEASSERT: begin
                done_nxt = !ack_s;
            end
            default: begin
                req_nxt  = 1'b0;
                done_nxt = 1'b0;
            end
        endcase
    end

    // Output registers; the data word only moves on an accepted request so it
    // stays stable across the whole handshake and after completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_q  <= 1'b0;
            done_q <= 1'b0;
            data_q <= '0;
        end else begin
            req_q  <= req_nxt;
            done_q <= done_nxt;
            if (load) begin
                data_q <= bus.req_data_i;
            end
        end
    end

    assign bus.idle_o     = idle;
    assign bus.req_o      = req_q;
    assign bus.req_data_o = data_q;
    assign bus.done_o     = done_q;

endmodule

// File: tb/tb_full_handshake_tx.sv
`timescale 1ns/1ps
// Directed bench for full_handshake_tx with a behavioural RX responder.
// Latency: bench checks exact edge counts from accept and from ack edges.
// Backpressure: client stimulus waits on idle_o with bounded waits.
module tb_full_handshake_tx;

    localparam int DW = 32;

    logic clk;
    logic rst_n;
    logic rx_clk;
    real  rx_half = 7.0;

    full_handshake_tx_if #(.DW(DW)) bus ();

    full_handshake_tx #(.DW(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    // behavioural RX responder state
    logic          rx_en;
    logic          ack_man;
    logic          ack_rsp;
    logic          rq1;
    logic          rq2;
    int            rx_cnt;
    int            rx_delay;
    logic [DW-1:0] rx_q[$];

    int n_checks;
    int n_fail;
    int done_total;
    int ack_run;

    assign bus.ack_i = rx_en ? ack_rsp : ack_man;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RX clock offset by half a ns so its edges never coincide with clk at the default ratio
    initial begin
        rx_clk = 1'b0;
        #0.5;
        forever #(rx_half) rx_clk = ~rx_clk;
    end

    // RX side: synchronize req, ack after rx_delay RX cycles, record the word, drop ack after req falls
    always @(posedge rx_clk) begin
        rq1 <= bus.req_o;
        rq2 <= rq1;
        if (!rx_en) begin
            rx_cnt  <= 0;
            ack_rsp <= 1'b0;
        end else if (rq2 && !ack_rsp) begin
            if (rx_cnt >= rx_delay - 1) begin
                ack_rsp <= 1'b1;
                rx_q.push_back(bus.req_data_o);
                rx_cnt  <= 0;
            end else begin
                rx_cnt <= rx_cnt + 1;
            end
        end else if (!rq2 && ack_rsp) begin
            ack_rsp <= 1'b0;
        end
    end

    // Count done pulses (each high for one cycle, seen once at the following edge)
    always @(posedge clk) begin
        if (bus.done_o === 1'b1) begin
            done_total <= done_total + 1;
        end
    end

    // Number of consecutive clk edges that have seen ack_i high
    always @(posedge clk) begin
        if (bus.ack_i === 1'b1) begin
            ack_run <= ack_run + 1;
        end else begin
            ack_run <= 0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // sel 0: wait idle_o=1; sel 1: wait req_o=0
    task automatic wait_cond(input int sel, input int budget, output bit ok, output int waited);
        ok = 1'b0;
        waited = 0;
        while (waited < budget) begin
            if (sel == 0 && bus.idle_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            if (sel == 1 && bus.req_o === 1'b0) begin
                ok = 1'b1;
                break;
            end
            step(1);
            waited++;
        end
    endtask

    task automatic send_word(input logic [DW-1:0] d);
        bit ok;
        int w;
        wait_cond(0, 2000, ok, w);
        check("send_wait_idle", ok, 1);
        bus.req_i      = 1'b1;
        bus.req_data_i = d;
        step(1);
        bus.req_i      = 1'b0;
        bus.req_data_i = '1;
    endtask

    initial begin
        bit   ok;
        int   w;
        int   d0;
        int   qb;
        int   dead_cnt;
        bit   stable;

        n_checks   = 0;
        n_fail     = 0;
        done_total = 0;
        ack_run    = 0;
        rx_en      = 1'b0;
        ack_man    = 1'b0;
        rx_delay   = 3;
        rx_cnt     = 0;
        ack_rsp    = 1'b0;
        rq1        = 1'b0;
        rq2        = 1'b0;
        rst_n      = 1'b0;
        bus.req_i      = 1'b0;
        bus.req_data_i = '0;

        // ---- reset state ----
        step(2);
        check("rst_req", bus.req_o, 0);
        check("rst_data", bus.req_data_o, 0);
        check("rst_done", bus.done_o, 0);
        rst_n = 1'b1;
        step(1);
        check("rst_idle", bus.idle_o, 1);

        // ---- manual-ack basic transfer with exact edge timing ----
        d0 = done_total;
        bus.req_i      = 1'b1;
        bus.req_data_i = 32'hA5A5_1234;
        step(1);
        bus.req_i      = 1'b0;
        bus.req_data_i = 32'h0BAD_0BAD;
        check("m_req_rise", bus.req_o, 1);
        check("m_data", bus.req_data_o, 32'hA5A5_1234);
        check("m_busy", bus.idle_o, 0);
        step(3);
        check("m_req_hold", bus.req_o, 1);
        ack_man = 1'b1;
        step(2);
        check("m_req_n1", bus.req_o, 1);
        step(1);
        check("m_req_n2", bus.req_o, 0);
        check("m_idle_deassert", bus.idle_o, 0);
        ack_man = 1'b0;
        step(2);
        check("m_done_m1", bus.done_o, 0);
        check("m_idle_m1", bus.idle_o, 0);
        step(1);
        check("m_done_m2", bus.done_o, 1);
        check("m_idle_m2", bus.idle_o, 1);
        check("m_data_after", bus.req_data_o, 32'hA5A5_1234);
        // earliest next acceptance at m+3
        bus.req_i      = 1'b1;
        bus.req_data_i = 32'h0000_0077;
        step(1);
        bus.req_i      = 1'b0;
        check("m_done_m3", bus.done_o, 0);
        check("m_next_req", bus.req_o, 1);
        check("m_next_data", bus.req_data_o, 32'h77);
        ack_man = 1'b1;
        step(3);
        ack_man = 1'b0;
        step(4);
        check("m_done_count", done_total - d0, 2);

        // ---- responder-based basic transfer ----
        rx_half  = 7.0;
        rx_delay = 3;
        rx_en    = 1'b1;
        d0 = done_total;
        qb = rx_q.size();
        send_word(32'hA5A5_1234);
        check("b_req_rise", bus.req_o, 1);
        wait_cond(1, 500, ok, w);
        check("b_wait_fall", ok, 1);
        check("b_fall_lat", ack_run, 3);
        check("b_data_hold", bus.req_data_o, 32'hA5A5_1234);
        wait_cond(0, 500, ok, w);
        check("b_wait_idle", ok, 1);
        step(2);
        check("b_done_count", done_total - d0, 1);
        check("b_rx_count", rx_q.size() - qb, 1);
        if (rx_q.size() > qb) check("b_rx_word", rx_q[qb], 32'hA5A5_1234);

        // ---- back-to-back at two RX clock ratios ----
        for (int r = 0; r < 2; r++) begin
            rx_half = (r == 0) ? 15.0 : 1.667;
            step(4);
            d0 = done_total;
            qb = rx_q.size();
            for (int i = 1; i <= 3; i++) begin
                send_word(i);
            end
            wait_cond(0, 2000, ok, w);
            check("bb_wait_idle", ok, 1);
            step(2);
            check("bb_done_count", done_total - d0, 3);
            check("bb_rx_count", rx_q.size() - qb, 3);
            for (int i = 0; i < 3; i++) begin
                if (rx_q.size() > qb + i) check("bb_rx_order", rx_q[qb + i], i + 1);
            end
        end

        // ---- busy drop ----
        rx_half  = 7.0;
        rx_delay = 10;
        step(4);
        d0 = done_total;
        qb = rx_q.size();
        send_word(32'h0000_0011);
        step(2);
        bus.req_i      = 1'b1;
        bus.req_data_i = 32'h0000_DEAD;
        step(1);
        bus.req_i      = 1'b0;
        check("bd_assert_data", bus.req_data_o, 32'h11);
        wait_cond(1, 1000, ok, w);
        check("bd_wait_fall", ok, 1);
        check("bd_deassert_busy", bus.idle_o, 0);
        bus.req_i      = 1'b1;
        bus.req_data_i = 32'h0000_DEAD;
        step(1);
        bus.req_i      = 1'b0;
        check("bd_deassert_data", bus.req_data_o, 32'h11);
        wait_cond(0, 1000, ok, w);
        check("bd_wait_idle", ok, 1);
        step(3);
        check("bd_no_new_req", bus.req_o, 0);
        check("bd_data_kept", bus.req_data_o, 32'h11);
        check("bd_done_count", done_total - d0, 1);
        check("bd_rx_count", rx_q.size() - qb, 1);
        dead_cnt = 0;
        foreach (rx_q[i]) if (rx_q[i] == 32'h0000_DEAD) dead_cnt++;
        check("bd_no_dead", dead_cnt, 0);

        // ---- reset mid-ASSERT ----
        rx_delay = 100;
        d0 = done_total;
        send_word(32'h0000_0055);
        step(2);
        check("rm_in_assert", bus.req_o, 1);
        rx_en = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        check("rm_req", bus.req_o, 0);
        check("rm_data", bus.req_data_o, 0);
        check("rm_done", bus.done_o, 0);
        step(2);
        rst_n = 1'b1;
        step(1);
        check("rm_idle", bus.idle_o, 1);
        check("rm_no_done", done_total - d0, 0);

        // ---- stale ack across reset ----
        ack_man = 1'b1;
        rst_n   = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(3);
        check("st_busy", bus.idle_o, 0);
        bus.req_i      = 1'b1;
        bus.req_data_i = 32'h0000_0099;
        step(1);
        bus.req_i      = 1'b0;
        check("st_ignored_req", bus.req_o, 0);
        check("st_ignored_data", bus.req_data_o, 0);
        ack_man = 1'b0;
        step(1);
        check("st_idle_m1", bus.idle_o, 0);
        step(1);
        check("st_idle_m2", bus.idle_o, 1);
        rx_delay = 3;
        rx_en    = 1'b1;
        d0 = done_total;
        qb = rx_q.size();
        send_word(32'h00C0_FFEE);
        check("st_next_req", bus.req_o, 1);
        wait_cond(1, 500, ok, w);
        wait_cond(0, 500, ok, w);
        check("st_next_idle", ok, 1);
        step(2);
        check("st_next_done", done_total - d0, 1);
        if (rx_q.size() > qb) check("st_next_rx", rx_q[qb], 32'h00C0_FFEE);
        else check("st_next_rx_count", rx_q.size() - qb, 1);

        // ---- slow ack ----
        rx_delay = 100;
        d0 = done_total;
        qb = rx_q.size();
        send_word(32'hBEEF_0001);
        stable = 1'b1;
        w = 0;
        while (w < 1000 && bus.req_o === 1'b1) begin
            if (bus.req_data_o !== 32'hBEEF_0001) stable = 1'b0;
            step(1);
            w++;
        end
        check("sl_fell", bus.req_o, 0);
        check("sl_long_wait", (w >= 100), 1);
        check("sl_data_stable", stable, 1);
        check("sl_no_early_done", done_total - d0, 0);
        wait_cond(0, 1000, ok, w);
        check("sl_wait_idle", ok, 1);
        step(2);
        check("sl_done_count", done_total - d0, 1);
        if (rx_q.size() > qb) check("sl_rx", rx_q[qb], 32'hBEEF_0001);
        else check("sl_rx_count", rx_q.size() - qb, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
